// File: rtl/io_periph_pkg.sv
// Shared decode constants, select enum and byte-merge helper for the peripheral bank.
// Pure declarations; no clocked logic.
package io_periph_pkg;

  localparam logic [9:0] WIDX_LEDR = 10'h000;
  localparam logic [9:0] WIDX_LEDG = 10'h001;
  localparam logic [9:0] WIDX_LCD  = 10'h002;
  localparam logic [9:0] WIDX_HEX0 = 10'h004;
  localparam logic [9:0] WIDX_SW   = 10'h040;

  typedef enum logic [2:0] {
    SEL_LEDR,
    SEL_LEDG,
    SEL_LCD,
    SEL_HEX,
    SEL_SW,
    SEL_NONE
  } sel_e;

  // HEX digits occupy one word each from WIDX_HEX0; digits past num_hex fall through to SEL_NONE.
  function automatic sel_e addr_decode(input logic [9:0] widx, input int num_hex);
    if (widx == WIDX_LEDR)      return SEL_LEDR;
    else if (widx == WIDX_LEDG) return SEL_LEDG;
    else if (widx == WIDX_LCD)  return SEL_LCD;
    else if (widx == WIDX_SW)   return SEL_SW;
    else if ((widx >= WIDX_HEX0) && (int'(widx) < int'(WIDX_HEX0) + num_hex)) return SEL_HEX;
    else                        return SEL_NONE;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  bmask);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (bmask[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/io_periph_bank_if.sv
// Core-side load/store bus into the peripheral bank.
// Single-cycle request pulse, ack one cycle later; no backpressure.
interface io_periph_bank_if;
  logic        req_i;
  logic        we_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  bmask_i;
  logic [31:0] rdata_o;
  logic        ack_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, bmask_i,
    input  rdata_o, ack_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, bmask_i,
    output rdata_o, ack_o
  );
endinterface

// File: rtl/io_periph_bank_sw_debounce.sv
// One switch bit: 2-FF synchroniser, plus stability counter when IO_DEBOUNCE_EN is defined.
// Latency 2 cycles (sync only) or 2 + DEB_CYCLES cycles (debounced); no backpressure.
module sw_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  output logic sw_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = sw_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  // Any cycle where the synced bit agrees with the stable value restarts the window.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) stable_d = sync_q;
      else                                 cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign sw_o = stable_q;
`else
  assign sw_o = sync_q;
`endif

endmodule

// File: rtl/io_periph_bank.sv
// Memory-mapped LEDR/LEDG/LCD/HEX output registers and switch input; optional debounce via IO_DEBOUNCE_EN.
// Latency: stores take effect on the request edge, loads/acks one cycle later; no backpressure.
module io_periph_bank
  import io_periph_pkg::*;
#(
  parameter int NUM_HEX    = 8,
  parameter int SW_W       = 17,
  parameter int LEDR_W     = 17,
  parameter int LEDG_W     = 8,
  parameter int DEB_CYCLES = 50000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  io_periph_bank_if.slave      bus,
  input  logic [SW_W-1:0]      io_sw_i,
  output logic [LEDR_W-1:0]    io_ledr_o,
  output logic [LEDG_W-1:0]    io_ledg_o,
  output logic [31:0]          io_lcd_o,
  output logic [NUM_HEX*7-1:0] io_hex_o
);

  localparam int HIDX_W = (NUM_HEX > 1) ? $clog2(NUM_HEX) : 1;

  logic [LEDR_W-1:0] ledr_q, ledr_d;
  logic [LEDG_W-1:0] ledg_q, ledg_d;
  logic [31:0]       lcd_q, lcd_d;
  logic [6:0]        hex_q [NUM_HEX];
  logic [6:0]        hex_d [NUM_HEX];
  logic [31:0]       rdata_q, rdata_d;
  logic              ack_q, ack_d;

  logic [9:0]        widx;
  logic [HIDX_W-1:0] hidx;
  sel_e              sel;
  logic [SW_W-1:0]   sw_val;
  logic              unused_addr;

  assign widx        = bus.addr_i[11:2];
  assign hidx        = HIDX_W'(widx - WIDX_HEX0);
  assign sel         = addr_decode(widx, NUM_HEX);
  assign unused_addr = ^bus.addr_i[1:0];

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sw_debounce (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .sw_i  (io_sw_i[i]),
      .sw_o  (sw_val[i])
    );
  end

  always_comb begin
    ledr_d  = ledr_q;
    ledg_d  = ledg_q;
    lcd_d   = lcd_q;
    hex_d   = hex_q;
    rdata_d = rdata_q;
    ack_d   = bus.req_i;

    // Registers narrower than 32 bits are merged zero-extended and truncated back.
    if (bus.req_i && bus.we_i) begin
      case (sel)
        SEL_LEDR: ledr_d = LEDR_W'(byte_merge(32'(ledr_q), bus.wdata_i, bus.bmask_i));
        SEL_LEDG: ledg_d = LEDG_W'(byte_merge(32'(ledg_q), bus.wdata_i, bus.bmask_i));
        SEL_LCD:  lcd_d  = byte_merge(lcd_q, bus.wdata_i, bus.bmask_i);
        SEL_HEX:  hex_d[hidx] = 7'(byte_merge(32'(hex_q[hidx]), bus.wdata_i, bus.bmask_i));
        default:  ;
      endcase
    end

    if (bus.req_i && !bus.we_i) begin
      case (sel)
        SEL_LEDR: rdata_d = 32'(ledr_q);
        SEL_LEDG: rdata_d = 32'(ledg_q);
        SEL_LCD:  rdata_d = lcd_q;
        SEL_HEX:  rdata_d = 32'(hex_q[hidx]);
        SEL_SW:   rdata_d = 32'(sw_val);
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ledr_q  <= '0;
      ledg_q  <= '0;
      lcd_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      for (int k = 0; k < NUM_HEX; k++) hex_q[k] <= '0;
    end else begin
      ledr_q  <= ledr_d;
      ledg_q  <= ledg_d;
      lcd_q   <= lcd_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      hex_q   <= hex_d;
    end
  end

  for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
    assign io_hex_o[7*k +: 7] = hex_q[k];
  end

  assign io_ledr_o   = ledr_q;
  assign io_ledg_o   = ledg_q;
  assign io_lcd_o    = lcd_q;
  assign bus.rdata_o = rdata_q;
  assign bus.ack_o   = ack_q;

endmodule

// File: tb/tb_io_periph_bank.sv
// Directed bench for io_periph_bank: register map, byte masks, acks, reset and switch latency.
// Expected switch latency follows IO_DEBOUNCE_EN as defined for the build.
module tb_io_periph_bank;

  localparam int NUM_HEX    = 8;
  localparam int SW_W       = 17;
  localparam int LEDR_W     = 17;
  localparam int LEDG_W     = 8;
  localparam int DEB_CYCLES = 4;
`ifdef IO_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
`else
  localparam bit DEB_ON = 1'b0;
`endif

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [SW_W-1:0]      io_sw_i;
  logic [LEDR_W-1:0]    io_ledr_o;
  logic [LEDG_W-1:0]    io_ledg_o;
  logic [31:0]          io_lcd_o;
  logic [NUM_HEX*7-1:0] io_hex_o;

  int errors = 0;
  int checks = 0;
  logic [NUM_HEX*7-1:0] hex_exp;
  int first;

  io_periph_bank_if bus ();

  io_periph_bank #(
    .NUM_HEX   (NUM_HEX),
    .SW_W      (SW_W),
    .LEDR_W    (LEDR_W),
    .LEDG_W    (LEDG_W),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .bus      (bus),
    .io_sw_i  (io_sw_i),
    .io_ledr_o(io_ledr_o),
    .io_ledg_o(io_ledg_o),
    .io_lcd_o (io_lcd_o),
    .io_hex_o (io_hex_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic acc(input logic we, input logic [11:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = a;
    bus.wdata_i = d;
    bus.bmask_i = m;
    tick();
    bus.req_i   = 1'b0;
  endtask

  // Back-to-back SW loads; returns the first load index (1-based edge) reading bit0 = 1, or 0.
  task automatic poll_sw(input int hold, output int first_one);
    first_one = 0;
    for (int k = 1; k <= 12; k++) begin
      acc(1'b0, 12'h100, 32'h0, 4'h0);
      if (k == hold) io_sw_i[0] = 1'b0;
      if (first_one == 0 && bus.rdata_o[0] === 1'b1) first_one = k;
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    bus.bmask_i = '0;
    io_sw_i     = '0;
    hex_exp     = '0;
    tick();
    tick();
    chk("rst_ledr", io_ledr_o, 0);
    chk("rst_ledg", io_ledg_o, 0);
    chk("rst_lcd", io_lcd_o, 0);
    chk("rst_hex", io_hex_o, 0);
    chk("rst_ack", bus.ack_o, 0);
    chk("rst_rdata", bus.rdata_o, 0);
    rst_ni = 1'b1;
    tick();

    acc(1'b1, 12'h000, 32'hDEADBEEF, 4'b0011);
    chk("ledr_st_ack", bus.ack_o, 1);
    chk("ledr_st", io_ledr_o, 17'h0BEEF);
    acc(1'b0, 12'h000, 32'h0, 4'h0);
    chk("ledr_ld_ack", bus.ack_o, 1);
    chk("ledr_ld", bus.rdata_o, 32'h0000BEEF);
    acc(1'b1, 12'h000, 32'hFFFFFFFF, 4'b1111);
    chk("ledr_full", io_ledr_o, 17'h1FFFF);
    acc(1'b0, 12'h000, 32'h0, 4'h0);
    chk("ledr_zext", bus.rdata_o, 32'h0001FFFF);
    acc(1'b1, 12'h002, 32'h00AA0000, 4'b0100);
    chk("ledr_byte2", io_ledr_o, 17'h0FFFF);

    acc(1'b1, 12'h02C, 32'h0000007F, 4'b0001);
    hex_exp[55:49] = 7'h7F;
    chk("hex7", io_hex_o, hex_exp);
    acc(1'b1, 12'h010, 32'hABCDEF55, 4'b1111);
    hex_exp[6:0] = 7'h55;
    chk("hex0", io_hex_o, hex_exp);
    acc(1'b1, 12'h034, 32'h0000007F, 4'b0001);
    chk("hex9_nochg", io_hex_o, hex_exp);
    chk("hex9_ack", bus.ack_o, 1);
    acc(1'b0, 12'h02C, 32'h0, 4'h0);
    chk("hex7_ld", bus.rdata_o, 32'h7F);
    acc(1'b0, 12'h030, 32'h0, 4'h0);
    chk("hex8_ld", bus.rdata_o, 32'h0);

    acc(1'b1, 12'h008, 32'h12345678, 4'b1111);
    acc(1'b1, 12'h008, 32'hAB000000, 4'b1000);
    chk("lcd_st", io_lcd_o, 32'hAB345678);
    acc(1'b0, 12'h008, 32'h0, 4'h0);
    chk("lcd_ld", bus.rdata_o, 32'hAB345678);
    acc(1'b0, 12'h200, 32'h0, 4'h0);
    chk("unmap_ld", bus.rdata_o, 32'h0);
    chk("unmap_ack", bus.ack_o, 1);

    acc(1'b1, 12'h004, 32'h00000012, 4'b1111);
    chk("b2b_st_ack", bus.ack_o, 1);
    chk("ledg_st", io_ledg_o, 8'h12);
    acc(1'b0, 12'h004, 32'h0, 4'h0);
    chk("b2b_ld_ack", bus.ack_o, 1);
    chk("b2b_ld", bus.rdata_o, 32'h12);
    tick();
    chk("idle_ack", bus.ack_o, 0);
    chk("idle_hold", bus.rdata_o, 32'h12);

    acc(1'b1, 12'h100, 32'hFFFFFFFF, 4'b1111);
    chk("sw_st_ack", bus.ack_o, 1);
    acc(1'b0, 12'h100, 32'h0, 4'h0);
    chk("sw_ro", bus.rdata_o, 32'h0);

    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = 12'h008;
    tick();
    rst_ni    = 1'b0;
    bus.req_i = 1'b0;
    #1;
    hex_exp = '0;
    chk("mid_rst_ack", bus.ack_o, 0);
    chk("mid_rst_rdata", bus.rdata_o, 0);
    chk("mid_rst_ledr", io_ledr_o, 0);
    chk("mid_rst_ledg", io_ledg_o, 0);
    chk("mid_rst_lcd", io_lcd_o, 0);
    chk("mid_rst_hex", io_hex_o, hex_exp);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("post_rst_ack", bus.ack_o, 0);

    io_sw_i[0] = 1'b1;
    poll_sw(3, first);
    chk("sw_glitch", first, DEB_ON ? 0 : 3);
    for (int i = 0; i < 20; i++) tick();
    io_sw_i[0] = 1'b1;
    poll_sw(10, first);
    chk("sw_hold", first, DEB_ON ? 7 : 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
